// File: rtl/spi_pkg.sv
// spi_pkg: shared frame layout, read/write encodings, default address limit and FSM states
package spi_pkg;
    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [ADDR_MSB-ADDR_LSB:0] MAX_ADDR_DEFAULT = 7'h04;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, ERR} state_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter producing one-clock SCLK edge strobes
// Ports: clk, rst_n (async, active-low); en runs the counter (cleared while low);
//        level is the current sclk value; rise_tick/fall_tick pulse on the last
//        clock of a half-period, telling which edge the controller takes next.
module spi_clk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic level,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int W = $clog2(CLK_DIV + 1);

    logic [W-1:0] cnt;
    logic         tick;

    assign tick      = en && cnt == W'(CLK_DIV - 1);
    assign rise_tick = tick && !level;
    assign fall_tick = tick && level;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (!en || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/spi_controller.sv
// spi_controller: register-access SPI mode-0 controller with 16-bit {rw, addr, data} frames
// Ports: clk, rst_n (async, active-low); host side req_valid/req_ready/req_rw/req_addr/req_data;
//        SPI side sclk/copi/ncs outputs and cipo input; rd_data holds the last read byte;
//        done pulses when a frame completes; err pulses on a rejected request.
// Build option: SPI_CTRL_ADDR_CHECK_EN rejects requests with req_addr > MAX_ADDR.
module spi_controller
    import spi_pkg::*;
#(
    parameter int         CLK_DIV  = 8,
    parameter int         CS_GAP   = 4,
    parameter logic [6:0] MAX_ADDR = MAX_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       err
);
    state_t               state, state_n;
    logic                 sclk_n, copi_n, ncs_n, done_n, rw, rw_n;
    logic [FRAME_W-1:0]   frame, shreg, shreg_n;
    logic [DATA_MSB:0]    rx, rx_n, rd_n;
    logic [4:0]           bit_cnt, bit_n;
    logic [7:0]           gap_cnt, gap_n;
    logic                 en, rise_tick, fall_tick, bad_addr;

    assign req_ready = state == IDLE;
    assign en        = state == SETUP || state == SHIFT || state == HOLD;
    assign frame     = {req_rw, req_addr, req_data};

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .level     (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

`ifdef SPI_CTRL_ADDR_CHECK_EN
    assign bad_addr = req_addr > MAX_ADDR;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err <= 1'b0;
        else        err <= req_valid && req_ready && bad_addr;
`else
    assign bad_addr = 1'b0;
    assign err      = 1'b0;
`endif

    // bit_cnt counts rising edges (0..16); SETUP and HOLD see sclk low, so their
    // end-of-period strobe arrives as rise_tick.
    always_comb begin
        state_n = state;
        sclk_n  = sclk;
        copi_n  = copi;
        ncs_n   = ncs;
        done_n  = 1'b0;
        rw_n    = rw;
        shreg_n = shreg;
        rx_n    = rx;
        rd_n    = rd_data;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        case (state)
            IDLE: if (req_valid) begin
                if (bad_addr) state_n = ERR;
                else begin
                    state_n = SETUP;
                    ncs_n   = 1'b0;
                    sclk_n  = 1'b0;
                    copi_n  = frame[RW_BIT];
                    shreg_n = frame;
                    rw_n    = req_rw;
                    rx_n    = '0;
                    bit_n   = '0;
                end
            end
            SETUP: if (rise_tick) state_n = SHIFT;
            SHIFT: if (rise_tick) begin
                sclk_n = 1'b1;
                bit_n  = bit_cnt + 5'd1;
                if (bit_cnt >= 5'd8) rx_n = {rx[DATA_MSB-1:0], cipo};
            end else if (fall_tick) begin
                sclk_n  = 1'b0;
                shreg_n = {shreg[FRAME_W-2:0], 1'b0};
                copi_n  = shreg[FRAME_W-2];
                if (bit_cnt == 5'd16) state_n = HOLD;
            end
            HOLD: if (rise_tick) begin
                state_n = GAP;
                ncs_n   = 1'b1;
                copi_n  = 1'b0;
                done_n  = 1'b1;
                gap_n   = '0;
                if (rw == RW_READ) rd_n = rx;
            end
            GAP: if (gap_cnt == 8'(CS_GAP - 1)) state_n = IDLE;
                 else gap_n = gap_cnt + 8'd1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            ncs     <= 1'b1;
            done    <= 1'b0;
            rw      <= RW_WRITE;
            shreg   <= '0;
            rx      <= '0;
            rd_data <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            sclk    <= sclk_n;
            copi    <= copi_n;
            ncs     <= ncs_n;
            done    <= done_n;
            rw      <= rw_n;
            shreg   <= shreg_n;
            rx      <= rx_n;
            rd_data <= rd_n;
            bit_cnt <= bit_n;
            gap_cnt <= gap_n;
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed checks of spi_controller plus a loopback receiver model
module tb_spi_controller;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req_valid = 1'b0, req_rw = 1'b0, cipo = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, sclk, copi, ncs, done, err;
    logic [7:0] rd_data;

    logic       v3 = 1'b0, rw3 = 1'b0;
    logic [6:0] a3 = '0;
    logic [7:0] d3 = '0;
    logic       ready3, sclk3, copi3, ncs3, done3, err3;
    logic [7:0] rd3;

    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(4), .CS_GAP(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .rd_data(rd_data), .done(done), .err(err)
    );

    spi_controller #(.CLK_DIV(3), .CS_GAP(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
        .req_rw(rw3), .req_addr(a3), .req_data(d3),
        .sclk(sclk3), .copi(copi3), .ncs(ncs3), .cipo(1'b0),
        .rd_data(rd3), .done(done3), .err(err3)
    );

    always @(negedge clk) begin
        done_cnt <= done_cnt + int'(done);
        err_cnt  <= err_cnt + int'(err);
    end

    // loopback receiver: every SPI line passes a 2-flop synchronizer
    bit [1:0]  s_sclk, s_ncs, s_copi;
    bit        p_sclk, p_ncs;
    bit [15:0] rx_sh;
    int        rx_n, rx_frames;
    bit [7:0]  rx_regs [0:127];
    always @(posedge clk) begin
        s_sclk <= {s_sclk[0], sclk3};
        s_ncs  <= {s_ncs[0], ncs3};
        s_copi <= {s_copi[0], copi3};
        p_sclk <= s_sclk[1];
        p_ncs  <= s_ncs[1];
        if (s_ncs[1]) rx_n <= 0;
        else if (s_sclk[1] && !p_sclk) begin
            rx_sh <= {rx_sh[14:0], s_copi[1]};
            rx_n  <= rx_n + 1;
        end
        if (s_ncs[1] && !p_ncs && rx_n == 16 && rx_sh[15]) begin
            rx_regs[rx_sh[14:8]] <= rx_sh[7:0];
            rx_frames <= rx_frames + 1;
        end
    end

    task automatic hs(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
        ok = 0;
        req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic measure(input logic [7:0] rbyte, output logic [15:0] cap, output int low,
                           output int rises, output int viol, output logic got_done,
                           output logic [7:0] rd, output bit ok);
        logic ps, pc;
        cap = '0; low = 0; rises = 0; viol = 0; got_done = 0; rd = '0; ok = 0; ps = 0; pc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ncs) begin
                if (low > 0) begin
                    got_done = done; rd = rd_data; ok = 1;
                    break;
                end
            end else low++;
            if (sclk && !ps) begin
                cap = {cap[14:0], copi};
                rises++;
            end
            if (sclk && ps && copi !== pc) viol++;
            ps = sclk; pc = copi;
            cipo = (rises >= 8 && rises < 16) ? rbyte[3'(15 - rises)] : 1'b0;
            @(negedge clk);
        end
        cipo = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (ncs !== 1'b1) begin failures++; $display("FAIL reset_ncs got=%b exp=1", ncs); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (copi !== 1'b0) begin failures++; $display("FAIL reset_copi got=%b exp=0", copi); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_write;
        bit ok, mok; logic [15:0] cap; int low, rises, viol, d0; logic gd; logic [7:0] rd;
        d0 = done_cnt;
        hs(1'b1, 7'h02, 8'hA5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_handshake got=timeout exp=accept"); end
        checks++; if ({ncs, sclk, copi} !== 3'b001) begin failures++; $display("FAIL wr_setup ncs_sclk_copi got=%b exp=001", {ncs, sclk, copi}); end
        measure(8'h00, cap, low, rises, viol, gd, rd, mok);
        checks++; if (!mok) begin failures++; $display("FAIL wr_frame_end got=timeout exp=ncs_high"); end
        checks++; if (cap !== 16'h82A5) begin failures++; $display("FAIL wr_copi_bits got=%h exp=82a5", cap); end
        checks++; if (low !== 136) begin failures++; $display("FAIL wr_ncs_low got=%0d exp=136", low); end
        checks++; if (rises !== 16) begin failures++; $display("FAIL wr_sclk_rises got=%0d exp=16", rises); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL wr_copi_stable got=%0d exp=0", viol); end
        checks++; if (gd !== 1'b1) begin failures++; $display("FAIL wr_done_at_ncs_rise got=%b exp=1", gd); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL wr_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_read;
        bit ok, mok; logic [15:0] cap; int low, rises, viol; logic gd; logic [7:0] rd;
        hs(1'b0, 7'h01, 8'h00, ok);
        measure(8'h3C, cap, low, rises, viol, gd, rd, mok);
        checks++; if (!ok || !mok) begin failures++; $display("FAIL rd_frame got=timeout exp=complete"); end
        checks++; if (cap !== 16'h0100) begin failures++; $display("FAIL rd_copi_bits got=%h exp=0100", cap); end
        checks++; if (gd !== 1'b1 || rd !== 8'h3C) begin failures++; $display("FAIL rd_data_at_done got=%b/%h exp=1/3c", gd, rd); end
        repeat (8) @(negedge clk);
        hs(1'b1, 7'h03, 8'h5A, ok);
        measure(8'hFF, cap, low, rises, viol, gd, rd, mok);
        checks++; if (cap !== 16'h835A) begin failures++; $display("FAIL wr2_copi_bits got=%h exp=835a", cap); end
        checks++; if (rd_data !== 8'h3C) begin failures++; $display("FAIL wr_keeps_rd_data got=%h exp=3c", rd_data); end
    endtask

    task automatic test_back_to_back;
        int hsn, frames, high, ngaps, bad, min_gap, d0;
        logic prev_ncs;
        hsn = 0; frames = 0; high = 0; ngaps = 0; bad = 0; min_gap = 9999; prev_ncs = 1'b1;
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        req_rw = 1'b1; req_addr = 7'h04; req_data = 8'h77; req_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (req_valid && req_ready) hsn++;
            else if (hsn >= 3) req_valid = 1'b0;
            if (ncs) high = prev_ncs ? high + 1 : 1;
            else if (prev_ncs) begin
                if (frames > 0) begin
                    ngaps++;
                    if (high < min_gap) min_gap = high;
                    if (high < 5) bad++;
                end
                frames++;
            end
            prev_ncs = ncs;
            if (frames == 3 && ncs && high >= 20) break;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (frames !== 3 || hsn !== 3) begin failures++; $display("FAIL b2b_frames got=%0d/%0d exp=3/3", frames, hsn); end
        checks++; if (ngaps !== 2 || bad !== 0) begin failures++; $display("FAIL b2b_gap got=min%0d exp=min>=5", min_gap); end
        checks++; if (done_cnt - d0 !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        bit ok, mok, hit; logic [15:0] cap; int low, rises, viol, edges, d0; logic gd, ps; logic [7:0] rd;
        d0 = done_cnt; edges = 0; hit = 0; ps = 1'b0;
        hs(1'b1, 7'h02, 8'hA5, ok);
        for (int i = 0; i < 500; i++) begin
            if (sclk !== ps) edges++;
            ps = sclk;
            if (edges == 7) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++; if (!hit || sclk !== 1'b1) begin failures++; $display("FAIL mid_edge7 got=%b exp=1", hit); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ncs, sclk, copi} !== 3'b100) begin failures++; $display("FAIL mid_rst_outputs got=%b exp=100", {ncs, sclk, copi}); end
        checks++; if (rd_data !== 8'h00 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_state got=%h/%b exp=00/1", rd_data, req_ready); end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - d0); end
        hs(1'b0, 7'h04, 8'h00, ok);
        measure(8'hC3, cap, low, rises, viol, gd, rd, mok);
        checks++; if (cap !== 16'h0400 || low !== 136) begin failures++; $display("FAIL mid_next_frame got=%h/%0d exp=0400/136", cap, low); end
        checks++; if (gd !== 1'b1 || rd !== 8'hC3) begin failures++; $display("FAIL mid_next_read got=%b/%h exp=1/c3", gd, rd); end
    endtask

    task automatic test_addr_check;
        bit ok, mok; logic [15:0] cap; int low, rises, viol, e0, lows; logic gd; logic [7:0] rd;
        repeat (8) @(negedge clk);
        e0 = err_cnt;
`ifdef SPI_CTRL_ADDR_CHECK_EN
        lows = 0;
        hs(1'b1, 7'h05, 8'h33, ok);
        checks++; if ({err, req_ready, ncs} !== 3'b101) begin failures++; $display("FAIL ac_reject got=%b exp=101", {err, req_ready, ncs}); end
        for (int i = 0; i < 150; i++) begin
            if (!ncs) lows++;
            @(negedge clk);
        end
        checks++; if (lows !== 0) begin failures++; $display("FAIL ac_ncs_stays_high got=%0d exp=0", lows); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ac_err_count got=%0d exp=1", err_cnt - e0); end
        hs(1'b1, 7'h04, 8'h11, ok);
        measure(8'h00, cap, low, rises, viol, gd, rd, mok);
        checks++; if (cap !== 16'h8411 || low !== 136) begin failures++; $display("FAIL ac_max_addr got=%h/%0d exp=8411/136", cap, low); end
`else
        hs(1'b1, 7'h05, 8'h33, ok);
        measure(8'h00, cap, low, rises, viol, gd, rd, mok);
        checks++; if (cap !== 16'h8533 || low !== 136) begin failures++; $display("FAIL noac_addr5 got=%h/%0d exp=8533/136", cap, low); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL noac_err got=%0d exp=0", err_cnt - e0); end
`endif
    endtask

    task automatic wr3(input logic [6:0] a, input logic [7:0] d, output bit ok);
        bit got;
        ok = 0; got = 0;
        rw3 = 1'b1; a3 = a; d3 = d; v3 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (ready3) begin
                @(posedge clk);
                got = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        v3 = 1'b0;
        for (int i = 0; i < 500 && got; i++) begin
            if (done3) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_loopback;
        logic [7:0] exp [0:4];
        logic [6:0] a; logic [7:0] d; bit ok; int timeouts, f0;
        timeouts = 0; f0 = rx_frames;
        for (int i = 0; i < 5; i++) begin
            a = 7'(i); d = 8'h10 + 8'(i);
            wr3(a, d, ok);
            exp[i] = d;
            if (!ok) timeouts++;
        end
        for (int i = 0; i < 100; i++) begin
            a = 7'($urandom_range(0, 4)); d = 8'($urandom);
            wr3(a, d, ok);
            exp[a] = d;
            if (!ok) timeouts++;
        end
        repeat (20) @(negedge clk);
        checks++; if (timeouts !== 0) begin failures++; $display("FAIL lb_timeouts got=%0d exp=0", timeouts); end
        checks++; if (rx_frames - f0 !== 105) begin failures++; $display("FAIL lb_frames got=%0d exp=105", rx_frames - f0); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_regs[i] !== exp[i]) begin failures++; $display("FAIL lb_reg%0d got=%h exp=%h", i, rx_regs[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_reset_mid;
        test_addr_check;
        test_loopback;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: system clocks per SCLK half-period; legal range 3..255.
REQ-002 SHALL have parameter CS_GAP, default 4: clocks that nCS is held high after a frame before the next request is accepted; legal range 2..255.
REQ-003 SHALL have parameter MAX_ADDR, default 7'h04: highest legal register address.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: host request valid.
REQ-007 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-008 SHALL have port req_rw, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 7 bits: register address.
REQ-010 SHALL have port req_data, input, 8 bits: write data.
REQ-011 SHALL have port sclk, output, 1 bit: SPI clock (mode 0).
REQ-012 SHALL have port copi, output, 1 bit: controller-out data.
REQ-013 SHALL have port ncs, output, 1 bit: chip select, active-low.
REQ-014 SHALL have port cipo, input, 1 bit: peripheral-out data, already synchronous to clk.
REQ-015 SHALL have port rd_data, output, 8 bits: last read result.
REQ-016 SHALL have port done, output, 1 bit: one-clock frame-complete pulse.
REQ-017 SHALL have port err, output, 1 bit: one-clock rejected-request pulse.

Function
REQ-018 SHALL assemble a 16-bit frame {req_rw, req_addr[6:0], req_data[7:0]}, latched at the handshake (req_valid && req_ready) and sent MSB first.
REQ-019 SHALL assert req_ready only in IDLE, combinationally from state.
REQ-020 SHALL implement the FSM IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; every non-IDLE state ignores req_valid.
REQ-021 SETUP: on the clock after the handshake, ncs=0, sclk=0 and copi=bit15; the state lasts CLK_DIV clocks.
REQ-022 SHIFT: sclk toggles every CLK_DIV clocks, giving 16 rising and 16 falling edges; copi advances to the next bit in the same clock sclk falls, and never changes while sclk is high.
REQ-023 HOLD: after the 16th falling edge, sclk=0 and ncs=0 for CLK_DIV clocks; then ncs=1 and done=1 for exactly that one clock.
REQ-024 Total ncs-low time SHALL be exactly 34*CLK_DIV clocks.
REQ-025 GAP: ncs=1 and copi=0 for CS_GAP clocks, then IDLE.
REQ-026 Read frames (rw=0): cipo SHALL be sampled in the clock of rising edges 9..16 and shifted into a data register MSB first; rd_data SHALL update in the done clock.
REQ-027 Write frames SHALL leave rd_data unchanged.
REQ-028 sclk, copi and ncs SHALL be driven directly from flops, so the outputs are glitch-free.
REQ-029 The half-period counter SHALL be $clog2(CLK_DIV+1) bits wide and reload to 0 on each sclk edge.
REQ-030 The bit counter SHALL be 5 bits and must not wrap within a frame.

Reset
REQ-031 Asserting rst_n low in any state SHALL immediately force: state=IDLE, ncs=1, sclk=0, copi=0, rd_data=8'h00, done=0, err=0, all counters 0.
REQ-032 A frame interrupted by reset SHALL be abandoned without a done pulse.
REQ-033 After reset is released, req_ready=1 from the first clock.

Configuration
REQ-034 With macro SPI_CTRL_ADDR_CHECK_EN defined, a handshake with req_addr > MAX_ADDR SHALL produce no frame: ncs stays 1, err=1 in the next clock, req_ready=0 during that clock, and the FSM then returns to IDLE.
REQ-035 Without SPI_CTRL_ADDR_CHECK_EN, every address SHALL be transmitted, err SHALL be tied to 0, and MAX_ADDR SHALL be unused.

Structure
REQ-036 Package spi_pkg SHALL hold: FRAME_W=16, RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7, the state enum, the RW_WRITE/RW_READ encodings and the MAX_ADDR default.
REQ-037 Sub-module spi_clk_gen SHALL hold the half-period counter and issue one-clock rise_tick and fall_tick strobes; spi_controller SHALL hold the FSM and shift registers.

Verification
REQ-038 Bench: CLK_DIV=4, write addr 0x02 data 0xA5 -> on sclk rising edges copi reads 1,0000010,10100101; ncs low 136 clocks; one done pulse.
REQ-039 Bench: read addr 0x01 with cipo driving 0x3C during the data bits -> rd_data=0x3C at done; copi data bits are 0x00.
REQ-040 Bench: req_valid held high for three back-to-back writes -> each ncs-high gap is >= CS_GAP+1 clocks; exactly three done pulses.
REQ-041 Bench: with SPI_CTRL_ADDR_CHECK_EN, write addr 0x05 -> err pulses once, ncs never falls; addr 0x04 -> frame sent normally.
REQ-042 Bench: rst_n low at sclk edge 7 -> in the same cycle ncs=1, sclk=0, no done; the next request completes correctly.
REQ-043 Bench: loop back into a receiver model using 2-flop synchronizers, CLK_DIV=3, 100 random in-range writes -> every register matches.
